// File: rtl/step_counter_7seg.sv
// Modulo-10^DIGITS BCD up/down counter with a fixed step, plus a time-multiplexed 7-segment driver.
// Count and wrap are registered; seg and an are decoded combinationally from the registered scan position.
module step_counter_7seg #(
    parameter int DIGITS   = 2,
    parameter int STEP     = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  odd,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [0:6]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [W-1:0]  step_val;
    logic          step_wrap;
    logic          load_ok;
    logic [4:0]    dig;
    logic [4:0]    delta;
    logic [4:0]    sum;
    logic          carry;

    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] dig_idx;
    logic [3:0]    sel;

    // Digit-serial BCD add/subtract: digit 0 takes STEP, upper digits take the carry/borrow.
    // The carry out of the top digit is exactly the modulus crossing.
    always_comb begin
        step_val = '0;
        carry    = 1'b0;
        load_ok  = 1'b1;
        dig      = '0;
        delta    = '0;
        sum      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig   = {1'b0, count[4*i +: 4]};
            delta = (i == 0) ? 5'(STEP) : {4'b0, carry};
            if (up) begin
                sum = dig + delta;
                if (sum >= 5'd10) begin
                    sum   = sum - 5'd10;
                    carry = 1'b1;
                end else begin
                    carry = 1'b0;
                end
            end else begin
                if (dig < delta) begin
                    sum   = dig + 5'd10 - delta;
                    carry = 1'b1;
                end else begin
                    sum   = dig - delta;
                    carry = 1'b0;
                end
            end
            step_val[4*i +: 4] = sum[3:0];
            if (load_val[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
        step_wrap = carry;
    end

    // An invalid load still wins over en: count holds, no step happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= {{(W-1){1'b0}}, odd};
            wrap  <= 1'b0;
        end else if (load) begin
            wrap <= 1'b0;
            if (load_ok) begin
                count <= load_val;
            end
        end else if (en) begin
            count <= step_val;
            wrap  <= step_wrap;
        end else begin
            wrap <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig_idx  <= (dig_idx == IW'(DIGITS - 1)) ? '0 : dig_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        sel = '0;
        an  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_idx == IW'(i)) begin
                sel   = count[4*i +: 4];
                an[i] = 1'b0;
            end
        end
    end

    always_comb begin
        case (sel)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001101;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_step_counter_7seg.sv
// Bench for step_counter_7seg at DIGITS=2, STEP=2, SCAN_DIV=4: directed vector table,
// corner-case sequences and random stimulus, all checked against an integer-valued model.
module tb_step_counter_7seg;

    localparam int DIGITS   = 2;
    localparam int STEP     = 2;
    localparam int SCAN_DIV = 4;
    localparam int M        = 100;

    logic       clk = 1'b0;
    logic       reset, odd, en, up, load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       wrap;
    logic [0:6] seg;
    logic [1:0] an;

    step_counter_7seg #(.DIGITS(DIGITS), .STEP(STEP), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .reset(reset), .odd(odd), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .wrap(wrap), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: plain decimal value, wrap flag, cycles since the last reset.
    int mv = 0;
    int mw = 0;
    int mt = 0;
    logic [6:0] seg_tab [10];

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    task automatic model_step();
        int lo, hi;
        if (reset) begin
            mv = odd ? 1 : 0;
            mw = 0;
            mt = 0;
        end else begin
            mt++;
            lo = int'(load_val[3:0]);
            hi = int'(load_val[7:4]);
            if (load) begin
                mw = 0;
                if (lo <= 9 && hi <= 9) mv = hi * 10 + lo;
            end else if (en) begin
                if (up) begin
                    mw = (mv + STEP >= M) ? 1 : 0;
                    mv = (mv + STEP) % M;
                end else begin
                    mw = (mv < STEP) ? 1 : 0;
                    mv = (mv - STEP + M) % M;
                end
            end else begin
                mw = 0;
            end
        end
    endtask

    // Advance one clock and compare every output against the model.
    task automatic tick();
        int d, digit;
        logic [6:0] s;
        model_step();
        @(posedge clk);
        #1;
        d     = (mt / SCAN_DIV) % DIGITS;
        digit = (d == 0) ? (mv % 10) : (mv / 10);
        s     = seg;
        chk("count", int'(count), to_bcd(mv));
        chk("wrap", int'(wrap), mw);
        chk("an", int'(an), (d == 0) ? 2 : 1);
        chk("seg", int'(s), int'(seg_tab[digit]));
    endtask

    task automatic set_in(input logic r, input logic o, input logic e, input logic u,
                          input logic l, input logic [7:0] lv);
        reset = r; odd = o; en = e; up = u; load = l; load_val = lv;
    endtask

    typedef struct {
        logic       reset, odd, en, up, load;
        logic [7:0] load_val;
        logic [7:0] exp_count;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs [15];
    int   wraps;

    initial begin
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001101; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0000100;

        //          rst  odd  en   up   load  load_val  count   wrap
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00,    8'h00, 1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00,    8'h98, 1'b1};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00,    8'h96, 1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 8'h10,    8'h10, 1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b1,1'b1, 8'h37,    8'h37, 1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b1,1'b1, 8'h3A,    8'h37, 1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 8'h00,    8'h39, 1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 8'h00,    8'h41, 1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 8'h99,    8'h99, 1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 8'h00,    8'h01, 1'b1};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 8'h00,    8'h01, 1'b0};
        vecs[11] = '{1'b1,1'b0,1'b1,1'b1,1'b1, 8'h55,    8'h00, 1'b0};
        vecs[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 8'h00,    8'h01, 1'b0};
        vecs[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 8'h00,    8'h99, 1'b1};
        vecs[14] = '{1'b0,1'b0,1'b1,1'b1,1'b1, 8'hA0,    8'h99, 1'b0};

        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        foreach (vecs[i]) begin
            set_in(vecs[i].reset, vecs[i].odd, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].load_val);
            tick();
            chk($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].exp_count));
            chk($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
        end

        // Even and odd full laps counting up: exactly one wrap, landing on the start value.
        for (int p = 0; p < 2; p++) begin
            set_in(1'b1, p[0], 1'b0, 1'b0, 1'b0, 8'h00);
            tick();
            set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            wraps = 0;
            for (int k = 0; k < 50; k++) begin
                tick();
                chk("lap_count", int'(count), to_bcd((p + STEP * (k + 1)) % M));
                if (wrap) wraps++;
            end
            chk("lap_wraps", wraps, 1);
            chk("lap_last_wrap", int'(wrap), 1);
        end

        // Hold 42 and watch the scan alternate between the digits.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 18; k++) tick();

        // Reset landing in the middle of a scan period returns to digit 0.
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
        tick();
        chk("midscan_an", int'(an), 2);

        for (int k = 0; k < 600; k++) begin
            logic [7:0] lv;
            lv = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                 {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            set_in($urandom_range(0, 49) == 0, 1'($urandom), $urandom_range(0, 3) != 0,
                   1'($urandom), $urandom_range(0, 7) == 0, lv);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
